// File: rtl/ram_pkg.sv
// Shared sizing constants and word/address types for the scratch RAM.
package ram_pkg;
    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_ADDR_WIDTH = 8;

    typedef logic [RAM_DATA_WIDTH-1:0] ram_word_t;
    typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;
endpackage

// File: rtl/ram_sync_256x8.sv
// Single-port synchronous scratch RAM with chip enable and a registered read port.
module ram_sync_256x8
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic wr_acc;
    logic rd_acc;

    assign wr_acc = en & wr;
    assign rd_acc = en & ~wr;

    // Array has no reset so it maps onto block RAM; rst only gates the write strobe.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[addr] <= data_in;
        end
    end

    // Read register: cleared asynchronously, otherwise holds until the next enabled read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= mem[addr];
        end
    end

endmodule

// File: tb/tb_ram_sync_256x8.sv
// Directed bench for ram_sync_256x8: expected read data is queued per step and checked after the edge.
module tb_ram_sync_256x8;

    logic       clk;
    logic       rst;
    logic       en;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int tests;
    int fails;

    logic [7:0] exp_q [$];
    string      tag_q [$];

    ram_sync_256x8 dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_out();
        logic [7:0] exp;
        string      tag;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard: queue empty, got nothing, required one entry");
            return;
        end
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        tests++;
        assert (data_out === exp)
        else begin
            fails++;
            $error("FAIL %s: data_out=0x%02h expected 0x%02h", tag, data_out, exp);
        end
    endtask

    // Drive one access at the falling edge, record the expected result, check after the rising edge.
    task automatic step(input logic e, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp, input string tag);
        @(negedge clk);
        en      = e;
        wr      = w;
        addr    = a;
        data_in = d;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        en      = 1'b0;
        wr      = 1'b0;
        addr    = 8'd0;
        data_in = 8'd0;

        step(1'b0, 1'b0, 8'd0, 8'd0, 8'h00, "reset_value");

        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 8'd5, 8'd99, 8'h00, "disabled_wr_0");
        step(1'b0, 1'b1, 8'd5, 8'd99, 8'h00, "disabled_wr_1");

        step(1'b1, 1'b1, 8'd5,  8'd25,  8'h00, "write_5_hold");
        step(1'b1, 1'b1, 8'd20, 8'd150, 8'h00, "write_20_hold");
        step(1'b1, 1'b0, 8'd5,  8'd0,   8'd25, "read_5");
        step(1'b0, 1'b0, 8'd0,  8'd0,   8'd25, "idle_hold_25");

        step(1'b1, 1'b1, 8'd33, 8'd77, 8'd25,  "write_33_hold");
        step(1'b1, 1'b0, 8'd20, 8'd0,  8'd150, "read_20");
        step(1'b1, 1'b0, 8'd33, 8'd0,  8'd77,  "read_33");
        step(1'b0, 1'b0, 8'd0,  8'd0,  8'd77,  "idle_hold_77a");
        step(1'b0, 1'b1, 8'd1,  8'd3,  8'd77,  "idle_hold_77b");

        step(1'b1, 1'b1, 8'd255, 8'hA5, 8'd77,  "write_255");
        step(1'b1, 1'b0, 8'd255, 8'h00, 8'hA5,  "turnaround_255");
        step(1'b1, 1'b1, 8'd0,   8'h3C, 8'hA5,  "write_0");
        step(1'b1, 1'b0, 8'd0,   8'h00, 8'h3C,  "read_0");

        step(1'b1, 1'b0, 8'd33, 8'h00, 8'd77, "read_33_pre_rst");
        step(1'b1, 1'b1, 8'd9,  8'h44, 8'd77, "write_9");

        // Pulse reset between edges; the output must clear with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(8'h00);
        tag_q.push_back("async_clear");
        check_out();

        step(1'b1, 1'b1, 8'd9,  8'h55, 8'h00, "rst_write_ignored");
        step(1'b1, 1'b0, 8'd33, 8'h00, 8'h00, "rst_read_ignored");
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'd33, 8'h00, 8'd77, "read_33_post_rst");
        step(1'b1, 1'b0, 8'd9,  8'h00, 8'h44, "read_9_preserved");

        step(1'b1, 1'b0, 8'd20, 8'h00, 8'd150, "read_20_again");
        step(1'b0, 1'b1, 8'd20, 8'h00, 8'd150, "dis_hold_0");
        step(1'b0, 1'b0, 8'd77, 8'hEE, 8'd150, "dis_hold_1");
        step(1'b0, 1'b1, 8'd20, 8'h5A, 8'd150, "dis_hold_2");
        step(1'b1, 1'b0, 8'd20, 8'h00, 8'd150, "mem20_unchanged");
        step(1'b1, 1'b0, 8'd5,  8'h00, 8'd25,  "mem5_not_99");

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
